// File: rtl/game_timer.sv
// rtl/game_timer.sv - Game countdown timer with internal tick, pre-start delay, pause, win freeze and BCD out
module game_timer #(
    parameter int WIDTH       = 8,
    parameter int START_COUNT = 45,
    parameter int DELAY_COUNT = 3,
    parameter int TICK_DIV    = 50000000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             startkey,
    input  logic             playkey,
    input  logic             pause,
    input  logic             win,
    output logic [WIDTH-1:0] countdown,
    output logic [WIDTH-1:0] delay,
    output logic [2:0]       state,
    output logic             running,
    output logic             expired,
    output logic [3:0]       ones,
    output logic [3:0]       tens
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_RUN     = 3'd2,
        S_WON     = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    state_t        st;
    logic [CW-1:0] tick_cnt;
    logic          start_q, start_qq;
    logic          play_q, play_qq;
    logic          expire_pend;
    logic          start_press;
    logic          play_press;
    logic          counting;
    logic          tick;

    // Keys are sampled once more so a press seen at one edge acts at the next.
    assign start_press = start_qq & ~start_q;
    assign play_press  = play_qq & ~play_q;
    assign counting    = ((st == S_DELAY) || (st == S_RUN)) && !pause;
    assign tick        = counting && (tick_cnt == CW'(TICK_DIV - 1));

    assign state   = st;
    assign running = (st == S_RUN);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st          <= S_IDLE;
            countdown   <= WIDTH'(START_COUNT);
            delay       <= WIDTH'(DELAY_COUNT);
            tick_cnt    <= '0;
            start_q     <= 1'b1;
            start_qq    <= 1'b1;
            play_q      <= 1'b1;
            play_qq     <= 1'b1;
            expire_pend <= 1'b0;
            expired     <= 1'b0;
            ones        <= 4'(START_COUNT % 10);
            tens        <= 4'((START_COUNT / 10) % 10);
        end else begin
            start_q     <= startkey;
            start_qq    <= start_q;
            play_q      <= playkey;
            play_qq     <= play_q;
            expired     <= expire_pend;
            expire_pend <= 1'b0;
            ones        <= 4'(countdown % WIDTH'(10));
            tens        <= 4'((countdown / WIDTH'(10)) % WIDTH'(10));

            if (start_press) begin
                st        <= S_IDLE;
                countdown <= WIDTH'(START_COUNT);
                delay     <= WIDTH'(DELAY_COUNT);
                tick_cnt  <= '0;
            end else begin
                if (counting) begin
                    if (tick)
                        tick_cnt <= '0;
                    else
                        tick_cnt <= tick_cnt + CW'(1);
                end

                case (st)
                    S_IDLE: begin
                        if (play_press) begin
                            tick_cnt <= '0;
                            st       <= (DELAY_COUNT == 0) ? S_RUN : S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        if (tick) begin
                            tick_cnt <= '0;
                            if (delay <= WIDTH'(1)) begin
                                delay <= '0;
                                st    <= S_RUN;
                            end else begin
                                delay <= delay - WIDTH'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        // A win on the same cycle as a tick keeps the pre-tick count.
                        if (win) begin
                            st <= S_WON;
                        end else if (tick) begin
                            if (countdown <= WIDTH'(1)) begin
                                countdown   <= '0;
                                st          <= S_EXPIRED;
                                expire_pend <= 1'b1;
                            end else begin
                                countdown <= countdown - WIDTH'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/game_timer.md
# game_timer

Parametrised game countdown timer for the maze game. It supersedes the fixed 45-second timer and its external clock divider. It runs from the system clock with an internal tick generator, supports a pre-start delay, pause, and a win freeze. It flags expiry and drives registered BCD digits straight to the HEX decoders.

## Interface
- WIDTH, 8, bit width of countdown and delay counters
- START_COUNT, 45, countdown load value in ticks; must be ≤ 99 and < 2^WIDTH
- DELAY_COUNT, 3, pre-start delay load value in ticks; 0 is legal
- TICK_DIV, 50000000, clock cycles per tick; must be ≥ 2

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- startkey  in  1  active-low key; press re-arms the timer
- playkey  in  1  active-low key; press starts the delay phase
- pause  in  1  active-high; freezes tick and counters in DELAY/RUN
- win  in  1  active-high; freezes the timer in RUN
- countdown  out  WIDTH  remaining game ticks
- delay  out  WIDTH  remaining delay ticks
- state  out  3  IDLE=0, DELAY=1, RUN=2, WON=3, EXPIRED=4
- running  out  1  high while state==RUN
- expired  out  1  one-cycle pulse when countdown reaches 0
- ones  out  4  BCD units of countdown
- tens  out  4  BCD tens of countdown

## Operation
- Key inputs arrive synchronised from upstream.
- A press is a falling edge, detected against a registered copy of each key. The registered copies reset to 1.
- Tick generator: counter runs 0..TICK_DIV-1 and pulses `tick` for one cycle at TICK_DIV-1. It counts only in DELAY or RUN with pause=0, and holds while pause=1. It clears to 0 on a startkey press and on entry to DELAY or RUN.
- The FSM evaluates in priority order; the first match wins.
  1. startkey press (any state): countdown=START_COUNT, delay=DELAY_COUNT, state=IDLE, tick counter=0. A same-cycle playkey press is ignored.
  2. IDLE + playkey press: go to DELAY. If DELAY_COUNT==0, go directly to RUN.
  3. DELAY + tick: delay decrements. If it was 1, delay becomes 0 and state becomes RUN in the same cycle.
  4. RUN + win=1: go to WON and hold countdown. A same-cycle tick is discarded.
  5. RUN + tick: countdown decrements. If it was 1, countdown becomes 0, state becomes EXPIRED, and expired pulses next cycle.
- WON and EXPIRED hold all counters until a startkey press. playkey, win and pause are ignored there.
- win outside RUN is ignored. playkey presses in DELAY/RUN/WON/EXPIRED are ignored.
- Counters never wrap below 0.
- BCD digits are registered from countdown: ones=countdown%10, tens=(countdown/10)%10.

## Timing
- Reset values: state=IDLE, countdown=START_COUNT, delay=DELAY_COUNT, running=0, expired=0, ones=START_COUNT%10, tens=START_COUNT/10, tick counter=0.
- A key press sampled at edge n takes effect in state and counters at edge n+1.
- From playkey press to RUN: 1 + DELAY_COUNT*TICK_DIV cycles while unpaused.
- Full run: START_COUNT*TICK_DIV cycles from RUN entry to countdown==0.
- expired is registered and rises one cycle after countdown becomes 0; it lasts exactly 1 cycle.
- ones/tens lag countdown by 1 cycle.
- running follows state combinationally.
- Asserting resetn low mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.
- A pause held for k cycles stretches the current tick period by exactly k cycles.

## Test plan
Bench parameters: TICK_DIV=4, START_COUNT=12, DELAY_COUNT=3, WIDTH=8.

- **Normal run:** reset, then press playkey → state=DELAY. delay reads 3,2,1,0 at 4-cycle intervals. RUN is entered 13 cycles after the press. countdown reaches 0 after 48 more cycles. expired pulses for 1 cycle, then state=EXPIRED and holds.
- **Win freeze:** in RUN at countdown=7, assert win in the same cycle as a tick → state=WON, countdown stays 7, ones=7, tens=0. A later playkey press has no effect.
- **Pause:** in RUN at countdown=10, hold pause for 9 cycles → countdown stays 10, and the next decrement arrives exactly 9 cycles later than unpaused.
- **Restart priority:** press startkey and playkey together from EXPIRED → state=IDLE, countdown=12, delay=3. The next lone playkey press enters DELAY.
- **Async reset mid-run:** drop resetn at countdown=5 between clock edges → countdown=12, state=IDLE, ones=2, tens=1 before the next edge.
- **Zero delay:** with DELAY_COUNT=0, a playkey press → state=RUN at the next edge, and the first decrement arrives 4 cycles later.
